// File: rtl/poly_pipe_pkg.sv
// Shared rasterizer parameters for the micropolygon pipeline.
// Defines the default payload geometry, the depth limit and the payload typedefs.
package poly_pipe_pkg;

  localparam int SIGFIG         = 24;
  localparam int VERTS          = 3;
  localparam int AXIS           = 3;
  localparam int COLORS         = 3;
  localparam int PIPE_DEPTH_MAX = 8;

  typedef logic [AXIS-1:0][SIGFIG-1:0]   vertex_t;
  typedef vertex_t [VERTS-1:0]           poly_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;

  // Width of a flattened payload: vertices, colours and the quad flag.
  function automatic int unsigned payload_width(int unsigned sigfig, int unsigned verts,
                                                int unsigned axis, int unsigned colors);
    return verts * axis * sigfig + colors * sigfig + 1;
  endfunction

endpackage

// File: rtl/poly_pipe_stage.sv
// One elastic pipeline stage: a valid flag and a payload register.
// The valid flag follows the upstream valid whenever the stage is ready.
// The payload register loads only on an actual load, so it holds its value through bubbles.
module poly_pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         load,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Valid flag: tracks the upstream valid when ready, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst)      valid <= 1'b0;
    else if (rdy) valid <= up_valid;
  end

  // Payload: loads only on a real load.
  always_ff @(posedge clk) begin
    if (rst)       data <= '0;
    else if (load) data <= up_data;
  end

endmodule

// File: rtl/poly_pipe.sv
// Elastic micropolygon pipeline of DEPTH stages with bubble collapse.
// Optional statistics outputs are enabled by defining POLY_PIPE_STATS_EN.
import poly_pipe_pkg::*;

module poly_pipe #(
  parameter int SIGFIG = poly_pipe_pkg::SIGFIG,
  parameter int VERTS  = poly_pipe_pkg::VERTS,
  parameter int AXIS   = poly_pipe_pkg::AXIS,
  parameter int COLORS = poly_pipe_pkg::COLORS,
  parameter int DEPTH  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]    poly_i,
  input  logic [COLORS*SIGFIG-1:0]        color_i,
  input  logic                            isQuad_i,
  input  logic                            valid_i,
  output logic                            halt_o,
  output logic [VERTS*AXIS*SIGFIG-1:0]    poly_o,
  output logic [COLORS*SIGFIG-1:0]        color_o,
  output logic                            isQuad_o,
  output logic                            valid_o,
  input  logic                            halt_i,
  output logic [$clog2(DEPTH+1)-1:0]      occ_o
`ifdef POLY_PIPE_STATS_EN
  ,
  output logic [31:0]                     xfer_cnt_o,
  output logic [31:0]                     stall_cnt_o,
  output logic [$clog2(DEPTH+1)-1:0]      occ_max_o
`endif
);

  localparam int PW = int'(payload_width(SIGFIG, VERTS, AXIS, COLORS));
  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] v_nxt;
  logic [PW-1:0]    up_d [DEPTH];
  logic [PW-1:0]    d    [DEPTH];
  logic [OW-1:0]    occ_nxt;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_v[k] = valid_i;
      assign up_d[k] = {poly_i, color_i, isQuad_i};
    end else begin : g_body
      assign up_v[k] = v[k-1];
      assign up_d[k] = d[k-1];
    end

    // Unrolled ready chain: stage k may advance if any stage from k to the output is empty or the output drains.
    assign rdy[k] = ~(&v[DEPTH-1:k]) | ~halt_i;

    poly_pipe_stage #(.W(PW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy[k]),
      .load     (rdy[k] & up_v[k]),
      .up_valid (up_v[k]),
      .up_data  (up_d[k]),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  assign halt_o                        = ~rdy[0];
  assign valid_o                       = v[DEPTH-1];
  assign {poly_o, color_o, isQuad_o}   = d[DEPTH-1];

  // Next-state valid vector and its population count.
  always_comb begin
    v_nxt   = (rdy & up_v) | (~rdy & v);
    occ_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + OW'(v_nxt[i]);
  end

  // Occupancy register reflects the state after each edge.
  always_ff @(posedge clk) begin
    if (rst) occ_o <= '0;
    else     occ_o <= occ_nxt;
  end

`ifdef POLY_PIPE_STATS_EN
  // Transfer/stall counters (wrapping) and peak occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_o  <= '0;
      stall_cnt_o <= '0;
      occ_max_o   <= '0;
    end else begin
      if (valid_o && !halt_i) xfer_cnt_o  <= xfer_cnt_o + 32'd1;
      if (valid_o && halt_i)  stall_cnt_o <= stall_cnt_o + 32'd1;
      if (occ_nxt > occ_max_o) occ_max_o  <= occ_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_poly_pipe.sv
// Self-checking bench for poly_pipe (DEPTH=3): directed scenarios plus random traffic,
// compared every cycle against a slot-level reference model and an in-order scoreboard.
module tb_poly_pipe;
  import poly_pipe_pkg::*;

  localparam int D  = 3;
  localparam int PL = VERTS * AXIS * SIGFIG;
  localparam int CL = COLORS * SIGFIG;
  localparam int PW = PL + CL + 1;
  localparam int OW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PL-1:0] poly_i = '0;
  logic [CL-1:0] color_i = '0;
  logic          isQuad_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          halt_i = 1'b0;
  logic          halt_o;
  logic [PL-1:0] poly_o;
  logic [CL-1:0] color_o;
  logic          isQuad_o;
  logic          valid_o;
  logic [OW-1:0] occ_o;
`ifdef POLY_PIPE_STATS_EN
  logic [31:0]   xfer_cnt_o;
  logic [31:0]   stall_cnt_o;
  logic [OW-1:0] occ_max_o;
`endif

  poly_pipe #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .poly_i   (poly_i),
    .color_i  (color_i),
    .isQuad_i (isQuad_i),
    .valid_i  (valid_i),
    .halt_o   (halt_o),
    .poly_o   (poly_o),
    .color_o  (color_o),
    .isQuad_o (isQuad_o),
    .valid_o  (valid_o),
    .halt_i   (halt_i),
    .occ_o    (occ_o)
`ifdef POLY_PIPE_STATS_EN
    ,
    .xfer_cnt_o  (xfer_cnt_o),
    .stall_cnt_o (stall_cnt_o),
    .occ_max_o   (occ_max_o)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: which slots hold a polygon and what it carries.
  bit            mv [D];
  logic [PW-1:0] md [D];
  int            mocc = 0;
  logic [PW-1:0] expq [$];
  bit            just_reset = 1'b0;
  int            xfers = 0, stalls = 0, occ_peak = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_payload(input int id);
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
    t[7:0] = id[7:0];
    return t[PW-1:0];
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model with the edge.
  task automatic step(input bit vi, input bit hi, input bit r, input int id);
    logic [PW-1:0] pl;
    logic [PW-1:0] dout;
    logic [PW-1:0] head;
    bit            full;
    bit            nv [D];
    logic [PW-1:0] nd [D];
    bit            can;
    bit            upv;
    logic [PW-1:0] upd;
    @(negedge clk);
    pl = rand_payload(id);
    valid_i = vi; halt_i = hi; rst = r;
    {poly_i, color_i, isQuad_i} = pl;
    #1;
    full = 1'b1;
    for (int k = 0; k < D; k++) if (!mv[k]) full = 1'b0;
    dout = {poly_o, color_o, isQuad_o};
    if (!r) begin
      check("valid_o", 512'(valid_o), 512'(mv[D-1]));
      check("halt_o", 512'(halt_o), 512'(full && hi));
      check("occ_o", 512'(occ_o), 512'(mocc));
      if (just_reset) check("rst_poly_o", 512'(poly_o), 512'(0));
      if (mv[D-1]) check("payload", 512'(dout), 512'(md[D-1]));
      if (mv[D-1] && !hi) begin
        if (expq.size() == 0) check("order_underflow", 512'(1), 512'(0));
        else begin
          head = expq.pop_front();
          check("order", 512'(dout), 512'(head));
        end
      end
    end
    if (r) begin
      for (int k = 0; k < D; k++) begin nv[k] = 1'b0; nd[k] = '0; end
      expq.delete();
      just_reset = 1'b1;
      xfers = 0; stalls = 0; occ_peak = 0;
    end else begin
      just_reset = 1'b0;
      if (mv[D-1] && !hi) xfers++;
      if (mv[D-1] && hi) stalls++;
      if (vi && !(full && hi)) expq.push_back(pl);
      for (int k = 0; k < D; k++) begin
        can = !hi;
        for (int j = k; j < D; j++) if (!mv[j]) can = 1'b1;
        upv = (k == 0) ? vi : mv[(k == 0) ? 0 : k-1];
        upd = (k == 0) ? pl : md[(k == 0) ? 0 : k-1];
        nv[k] = can ? upv : mv[k];
        nd[k] = (can && upv) ? upd : md[k];
      end
    end
    @(posedge clk);
    mocc = 0;
    for (int k = 0; k < D; k++) begin
      mv[k] = nv[k]; md[k] = nd[k];
      if (nv[k]) mocc++;
    end
    if (mocc > occ_peak) occ_peak = mocc;
  endtask

  initial begin
    for (int k = 0; k < D; k++) begin mv[k] = 1'b0; md[k] = '0; end
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    // Streaming IDs 1..10 then drain.
    for (int i = 1; i <= 10; i++) step(1, 0, 0, i);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // Collapse: 5, bubble, 6, then halt while 5 is at the output.
    step(1, 0, 0, 5); step(0, 0, 0, 0); step(1, 0, 0, 6);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // Full stall then simultaneous leave/enter.
    step(1, 0, 0, 1); step(1, 0, 0, 2); step(1, 0, 0, 3);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 4);
    step(1, 0, 0, 4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // Reset with two entries in flight, then ID 9.
    step(1, 0, 0, 1); step(1, 0, 0, 2);
    step(0, 0, 1, 0);
    step(1, 0, 0, 9);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // Empty pipe with halt asserted.
    step(1, 1, 0, 7);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
`ifdef POLY_PIPE_STATS_EN
    step(0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) step(1, (i == 4 || i == 5 || i == 6 || i == 7), 0, i);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    check("xfer_cnt_o", 512'(xfer_cnt_o), 512'(xfers));
    check("stall_cnt_o", 512'(stall_cnt_o), 512'(stalls));
    check("occ_max_o", 512'(occ_max_o), 512'(occ_peak));
`endif
    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
           bit'($urandom_range(0, 99) == 0), i);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    check("drained", 512'(expq.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/poly_pipe.md
# poly_pipe

Parametrised elastic pipeline for micropolygon payloads between rasterizer stages (bbox → iter → hash → sample). It replaces fixed-depth, halt-stalls-everything retiming with a per-stage valid pipeline of configurable depth. Bubbles are collapsed under backpressure, so a downstream halt only stalls the stages that are actually occupied. Payload geometry (vertices, axes, colour channels, bit width) is fully parametrised.

## Interface
Parameters:
- SIGFIG, default 24: bits per coordinate and colour value.
- VERTS, default 3: vertices per micropolygon.
- AXIS, default 3: axes per vertex.
- COLORS, default 3: colour channels.
- DEPTH, default 3: register stages; legal range 1..8.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- poly_i  in  VERTS*AXIS*SIGFIG  vertex payload.
- color_i  in  COLORS*SIGFIG  colour payload.
- isQuad_i  in  1  quad flag.
- valid_i  in  1  input polygon valid.
- halt_o  out  1  upstream must hold its input this cycle.
- poly_o, color_o, isQuad_o  out  same widths as inputs  output payload.
- valid_o  out  1  output polygon valid.
- halt_i  in  1  downstream refuses the output this cycle.
- occ_o  out  $clog2(DEPTH+1)  number of occupied stages.

## Operation
- Stage k holds v[k] and a payload register. Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- Ready chain (combinational):
  - rdy[DEPTH-1] = !v[DEPTH-1] || !halt_i.
  - rdy[k] = !v[k] || rdy[k+1].
- halt_o = !rdy[0].
- Input transfer: valid_i && rdy[0].
- Stage update, on each clock where rdy[k] is true:
  - Stage k loads stage k-1; stage 0 loads the input.
  - v[k] takes the upstream valid.
- Stages with rdy[k] false hold their contents.
- A payload register loads only when its incoming valid is 1. When the incoming valid is 0, only v[k] clears; the payload is held, which saves toggle power.
- Output transfer: valid_o && !halt_i.
- occ_o = popcount(v). It is registered so that it reflects the state after each clock edge.
- Boundaries:
  - Full pipe with halt_i=1: halt_o=1; no state changes.
  - Full pipe with halt_i falling in the same cycle that valid_i=1: output leaves and input enters in that cycle. No bubble is inserted and occ_o is unchanged.
  - Empty pipe: valid_o=0. halt_i is ignored, and halt_o=0 regardless of halt_i.
  - Bubble collapse: with halt_i=1 and a hole at stage k, stages below k advance until they are packed against the output.
- Reset, including mid-operation: all v cleared, all payload registers zeroed, occ_o=0, valid_o=0, halt_o=0. In-flight polygons are dropped.
- The block never reorders, duplicates or drops polygons outside reset.

## Timing
- Latency: DEPTH cycles from input transfer to valid_o, provided halt_i stays low.
- Throughput: one polygon per cycle sustained.
- halt_o depends combinationally on halt_i through a DEPTH-long AND chain.
- Outputs are registered. valid_o and the payload stay stable while halt_i=1.
- Each rdy term is at most DEPTH gates deep.

## Configuration
- POLY_PIPE_STATS_EN defined adds three outputs:
  - xfer_cnt_o (32 bits): output transfers.
  - stall_cnt_o (32 bits): cycles with valid_o && halt_i.
  - occ_max_o ($clog2(DEPTH+1) bits): peak occ_o.
- All three are cleared by rst. The 32-bit counters wrap modulo 2^32; occ_max_o saturates at DEPTH.
- POLY_PIPE_STATS_EN undefined: these ports and their registers do not exist. Datapath behaviour is identical in both builds.

## Structure
- Shared package (extends the rasterizer parameter package):
  - SIGFIG, VERTS, AXIS, COLORS defaults.
  - New constant PIPE_DEPTH_MAX = 8.
  - Typedefs: vertex_t [AXIS-1:0][SIGFIG-1:0], poly_t [VERTS-1:0] vertex_t, color_t [COLORS-1:0][SIGFIG-1:0].
- One sub-module, poly_pipe_stage: a single valid+payload register with incoming valid, rdy, and a load enable. poly_pipe instantiates DEPTH copies with a generate loop and builds the ready chain and occupancy logic.

## Test plan
All scenarios use DEPTH=3.
- Streaming: IDs 1..10 on consecutive cycles with halt_i=0 → valid_o first rises 3 cycles after ID 1 enters; IDs 1..10 appear in order on consecutive cycles; occ_o=3 in steady state.
- Collapse: insert ID 5, one idle cycle, ID 6. While ID 5 sits at the output (valid_o=1), hold halt_i=1 → one cycle later occ_o=2 with the two entries adjacent, and halt_o=0 until the pipe is full.
- Full stall: fill with IDs 1,2,3 and hold halt_i=1 for 5 cycles → halt_o=1 and valid_o=1 with ID 1 stable throughout. Then lower halt_i while valid_i=1 with ID 4 → ID 1 leaves and ID 4 is accepted in the same cycle.
- Reset mid-flight: two entries in flight, assert rst for 1 cycle → next cycle valid_o=0, occ_o=0, poly_o=0; ID 9 sent afterwards appears 3 cycles later.
- Empty with halt: halt_i=1 and the pipe empty → halt_o=0, and ID 7 is accepted.
- POLY_PIPE_STATS_EN: 10 transfers with 4 halted output cycles → xfer_cnt_o=10, stall_cnt_o=4, occ_max_o=3. Preload xfer_cnt_o to 0xFFFFFFFF, then one transfer → 0.
